// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register-access controller.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_BITS  = 7;
  localparam int DATA_BITS  = 8;

  function automatic logic addr_ok(input logic [ADDR_BITS-1:0] addr,
                                   input int unsigned num_regs);
    return 32'(addr) < num_regs;
  endfunction

endpackage

// File: rtl/synchronizer.sv
// Two-flop synchronizer for one asynchronous pin; holds its state while ena is low.
module synchronizer (
  input  logic rstb,
  input  logic clk,
  input  logic ena,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else if (ena) begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI mode-0 slave turning 16-bit frames into register writes and reads.
// Read frames are only supported when SPI_REG_READ_EN is defined.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8
) (
  input  logic                 rstb,
  input  logic                 clk,
  input  logic                 ena,
  input  logic                 spi_cs_n,
  input  logic                 spi_clk,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic                 reg_wr_en,
  output logic [ADDR_BITS-1:0] reg_addr,
  output logic [DATA_BITS-1:0] reg_wdata,
  input  logic [DATA_BITS-1:0] reg_rdata
);

  logic cs_s, sclk_s, mosi_s, sclk_prev;
  logic rise;

  synchronizer u_sync_cs   (.rstb(rstb), .clk(clk), .ena(ena), .d(spi_cs_n), .q(cs_s));
  synchronizer u_sync_sclk (.rstb(rstb), .clk(clk), .ena(ena), .d(spi_clk),  .q(sclk_s));
  synchronizer u_sync_mosi (.rstb(rstb), .clk(clk), .ena(ena), .d(spi_mosi), .q(mosi_s));

  assign rise = sclk_s & ~sclk_prev;

  state_t         state;
  logic [3:0]     bit_cnt;
  logic [6:0]     rx_shift;
  logic           cmd_wr;

`ifdef SPI_REG_READ_EN
  logic           fall;
  logic           load_pending;
  logic [6:0]     tx_rest;
  logic [7:0]     rd_byte;

  assign fall    = ~sclk_s & sclk_prev;
  assign rd_byte = addr_ok(reg_addr, NUM_REGS) ? reg_rdata : 8'h00;
`else
  logic unused_rdata;

  assign unused_rdata = ^reg_rdata;
  assign spi_miso     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state        <= IDLE;
      bit_cnt      <= 4'd0;
      rx_shift     <= 7'd0;
      cmd_wr       <= 1'b0;
      sclk_prev    <= 1'b0;
      reg_wr_en    <= 1'b0;
      reg_addr     <= '0;
      reg_wdata    <= '0;
`ifdef SPI_REG_READ_EN
      load_pending <= 1'b0;
      tx_rest      <= 7'd0;
      spi_miso     <= 1'b0;
`endif
    end else if (ena) begin
      sclk_prev <= sclk_s;
      reg_wr_en <= 1'b0;
      // Deselect overrides everything, including a 16th edge in the same cycle.
      if (cs_s) begin
        state   <= IDLE;
        bit_cnt <= 4'd0;
`ifdef SPI_REG_READ_EN
        load_pending <= 1'b0;
        tx_rest      <= 7'd0;
        spi_miso     <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            state    <= CMD;
            bit_cnt  <= 4'd0;
            rx_shift <= 7'd0;
          end
          CMD: begin
            if (rise) begin
              rx_shift <= {rx_shift[5:0], mosi_s};
              bit_cnt  <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                cmd_wr   <= rx_shift[6];
                reg_addr <= {rx_shift[5:0], mosi_s};
                state    <= DATA;
`ifdef SPI_REG_READ_EN
                load_pending <= ~rx_shift[6];
`endif
              end
            end
          end
          DATA: begin
            if (rise) begin
              rx_shift <= {rx_shift[5:0], mosi_s};
              bit_cnt  <= bit_cnt + 4'd1;
              if (bit_cnt == 4'(FRAME_BITS - 1)) begin
                state <= DONE;
                if (cmd_wr && addr_ok(reg_addr, NUM_REGS)) begin
                  reg_wr_en <= 1'b1;
                  reg_wdata <= {rx_shift, mosi_s};
                end
              end
            end
`ifdef SPI_REG_READ_EN
            // The fall right after the command byte must not shift: bit7 is sampled on the next rise.
            if (load_pending) begin
              load_pending <= 1'b0;
              spi_miso     <= rd_byte[7];
              tx_rest      <= rd_byte[6:0];
            end else if (fall && !cmd_wr && bit_cnt > 4'd8) begin
              spi_miso <= tx_rest[6];
              tx_rest  <= {tx_rest[5:0], 1'b0};
            end
`endif
          end
          DONE: begin
            state <= DONE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: table of directed frames plus abort/enable/reset sequences.
module tb_spi_reg_ctrl;
  import spi_reg_pkg::*;

`ifdef SPI_REG_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  logic       rstb, clk, ena;
  logic       spi_cs_n, spi_clk, spi_mosi, spi_miso;
  logic       reg_wr_en;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata, reg_rdata;

  int checks_total  = 0;
  int checks_passed = 0;

  int         wr_pulses = 0;
  logic [6:0] wr_addr   = '0;
  logic [7:0] wr_data   = '0;

  spi_reg_ctrl #(.NUM_REGS(8)) dut (
    .rstb      (rstb),
    .clk       (clk),
    .ena       (ena),
    .spi_cs_n  (spi_cs_n),
    .spi_clk   (spi_clk),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .reg_wr_en (reg_wr_en),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every cycle the strobe is high counts, so a stretched strobe shows up as extra pulses.
  always @(negedge clk) begin
    if (reg_wr_en) begin
      wr_pulses = wr_pulses + 1;
      wr_addr   = reg_addr;
      wr_data   = reg_wdata;
    end
  end

  typedef struct {
    logic [15:0] frame;
    logic [7:0]  rdata;
    int          exp_pulses;
    logic [6:0]  exp_addr;
    logic [7:0]  exp_wdata;
    logic [7:0]  exp_miso;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic spiBit(input logic b, output logic m);
    spi_mosi = b;
    repeat (8) @(negedge clk);
    spi_clk = 1'b1;
    m = spi_miso;
    repeat (8) @(negedge clk);
    spi_clk = 1'b0;
  endtask

  task automatic csLow();
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic csHigh();
    repeat (8) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Sends the first nbits of a frame; ena drops for 20 cycles before bit pause_at.
  task automatic applyStimulus(input logic [15:0] frame, input int nbits,
                               input int pause_at, output logic [7:0] miso_byte);
    logic m;
    miso_byte = 8'h00;
    csLow();
    for (int i = 0; i < nbits; i++) begin
      if (i == pause_at) begin
        ena = 1'b0;
        repeat (20) @(negedge clk);
        ena = 1'b1;
      end
      spiBit(frame[15-i], m);
      if (i >= 8) miso_byte[15-i] = m;
    end
    csHigh();
  endtask

  initial begin
    logic [7:0] miso_byte;
    int         base;

    vecs[0] = '{16'h835A, 8'h00, 1, 7'h03, 8'h5A, 8'h00};
    vecs[1] = '{16'h0500, 8'hC3, 0, 7'h05, 8'h00, READ_EN ? 8'hC3 : 8'h00};
    vecs[2] = '{16'hFF00, 8'h00, 0, 7'h7F, 8'h00, 8'h00};
    vecs[3] = '{16'h7F00, 8'hA5, 0, 7'h7F, 8'h00, 8'h00};
    vecs[4] = '{16'h87FF, 8'h00, 1, 7'h07, 8'hFF, 8'h00};
    vecs[5] = '{16'h8812, 8'h00, 0, 7'h08, 8'h00, 8'h00};
    vecs[6] = '{16'h0700, 8'h81, 0, 7'h07, 8'h00, READ_EN ? 8'h81 : 8'h00};

    rstb = 1'b0; ena = 1'b1; spi_cs_n = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
    reg_rdata = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset_miso",  32'(spi_miso),  32'h0);
    checkOutput("reset_wr_en", 32'(reg_wr_en), 32'h0);
    checkOutput("reset_addr",  32'(reg_addr),  32'h0);
    checkOutput("reset_wdata", 32'(reg_wdata), 32'h0);
    rstb = 1'b1;
    repeat (8) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      reg_rdata = vecs[i].rdata;
      base = wr_pulses;
      applyStimulus(vecs[i].frame, 16, -1, miso_byte);
      checkOutput($sformatf("v%0d_pulses", i), 32'(wr_pulses - base), 32'(vecs[i].exp_pulses));
      checkOutput($sformatf("v%0d_addr", i), 32'(reg_addr), 32'(vecs[i].exp_addr));
      checkOutput($sformatf("v%0d_miso", i), 32'(miso_byte), 32'(vecs[i].exp_miso));
      if (vecs[i].exp_pulses > 0) begin
        checkOutput($sformatf("v%0d_wr_addr", i), 32'(wr_addr), 32'(vecs[i].exp_addr));
        checkOutput($sformatf("v%0d_wdata", i), 32'(wr_data), 32'(vecs[i].exp_wdata));
      end
    end
    reg_rdata = 8'h00;

    // Frame aborted after 12 bits, then a clean write.
    base = wr_pulses;
    applyStimulus(16'h8599, 12, -1, miso_byte);
    checkOutput("abort_pulses", 32'(wr_pulses - base), 32'h0);
    base = wr_pulses;
    applyStimulus(16'h8111, 16, -1, miso_byte);
    checkOutput("after_abort_pulses", 32'(wr_pulses - base), 32'h1);
    checkOutput("after_abort_addr",   32'(wr_addr), 32'h01);
    checkOutput("after_abort_wdata",  32'(wr_data), 32'h11);

    // Enable dropped mid-frame with SCLK idle.
    base = wr_pulses;
    applyStimulus(16'h8244, 16, 10, miso_byte);
    checkOutput("ena_pulses", 32'(wr_pulses - base), 32'h1);
    checkOutput("ena_addr",   32'(wr_addr), 32'h02);
    checkOutput("ena_wdata",  32'(wr_data), 32'h44);

    // Reset during the data phase of a write to address 3.
    begin
      logic m;
      base = wr_pulses;
      csLow();
      for (int i = 0; i < 11; i++) spiBit(1'(16'h8333 >> (15 - i)), m);
      checkOutput("pre_rst_addr", 32'(reg_addr), 32'h03);
      @(negedge clk);
      rstb = 1'b0;
      #1;
      checkOutput("rst_miso",  32'(spi_miso),  32'h0);
      checkOutput("rst_wr_en", 32'(reg_wr_en), 32'h0);
      checkOutput("rst_addr",  32'(reg_addr),  32'h0);
      checkOutput("rst_wdata", 32'(reg_wdata), 32'h0);
      checkOutput("rst_state", 32'(dut.state), 32'(IDLE));
      spi_cs_n = 1'b1;
      spi_clk  = 1'b0;
      repeat (4) @(negedge clk);
      rstb = 1'b1;
      repeat (8) @(negedge clk);
      checkOutput("rst_pulses", 32'(wr_pulses - base), 32'h0);
    end
    base = wr_pulses;
    applyStimulus(16'h8466, 16, -1, miso_byte);
    checkOutput("post_rst_pulses", 32'(wr_pulses - base), 32'h1);
    checkOutput("post_rst_addr",   32'(wr_addr), 32'h04);
    checkOutput("post_rst_wdata",  32'(wr_data), 32'h66);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
